dsp_mac_slice: RTL and testbench
================================

# dsp_mac_slice

Parametrised successor to the team's DSP48A1-style slice. It computes a pre-add → multiply → post-add/accumulate with configurable operand widths, and adds three things the fixed slice lacks:
- a valid bit that travels with each sample, so accumulation counts only valid samples;
- a per-sample accumulator clear;
- optional saturating post-add.

It sits between sample sources and cascaded slices (BCOUT/PCOUT chaining).

## Interface
Parameters:
- A_W, 18, A operand width
- B_W, 18, B/D/BCIN/BCOUT width
- P_W, 48, C/PCIN/P/PCOUT width; must be ≥ A_W+B_W+2
- B_SRC, 0, 0: stage-1 B taken from B port, 1: from BCIN
- SAT_EN, 0, 1: post-add result clamps instead of wrapping

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  global clock enable; 0 freezes every register including valid bits
- in_valid  in  1  sample on A/B/D/C/PCIN/BCIN/opmode/acc_clr is valid
- acc_clr  in  1  forces Z operand to 0 for this sample
- opmode  in  8  operation select, travels with the sample
- A  in  A_W  multiplier operand
- B, D, BCIN  in  B_W  pre-adder operands / cascade B
- C, PCIN  in  P_W  post-adder operands
- BCOUT  out  B_W  stage-2 B value (pre-adder output)
- M  out  A_W+B_W  registered product
- P, PCOUT  out  P_W  result; PCOUT identical to P
- CARRYOUT, CARRYOUTF  out  1  raw post-add carry/borrow; CARRYOUTF identical
- sat  out  1  1 when the current P was clamped
- out_valid  out  1  P/CARRYOUT/sat hold a new valid result

## Operation
Opmode bits:
- [1:0] X select: 0 = zero, 1 = M, 2 = P, 3 = {D,A,B} zero-extended/truncated to P_W
- [3:2] Z select: 0 = zero, 1 = PCIN, 2 = P, 3 = C
- [4] pre-adder enable: B1 = D±B0; when 0, B1 = B0
- [5] carry-in bit
- [6] pre-add subtract: D−B0; 0 = D+B0
- [7] post-add subtract: Z−(X+cin); 0 = Z+X+cin

Arithmetic:
- All arithmetic is unsigned, modulo 2^B_W for the pre-add and 2^P_W for the post-add.
- CARRYOUT is bit P_W of the (P_W+1)-bit sum, or the borrow on subtract.
- When SAT_EN=1 and the operation overflows: add gives all-ones, subtract underflow gives 0, and sat=1. CARRYOUT still reports the raw carry/borrow.
- When acc_clr is set for a sample, its Z is forced to 0 regardless of opmode[3:2].

Valid gating:
- Stage-4 registers (P, CARRYOUT, sat) load only when the stage-3 valid bit is 1.
- Invalid cycles leave P untouched, so the accumulate (Z=P) path sums only valid samples.
- Stages 1–3 load every cycle when ce=1.

Reset:
- rst_n low asynchronously clears all registers.
- Every output and every internal valid bit resets to 0, including mid-operation; in-flight samples are discarded.

## Timing
Four-stage pipeline, each stage advancing on a clk edge with ce=1:
- Stage 1: register A0, B0 (B or BCIN per B_SRC), D0, C0, PCIN0, op0, clr0, v0.
- Stage 2: B1 = pre-add result; A1, D1, C1, PCIN1, op1, clr1, v1 are copies. BCOUT = B1.
- Stage 3: M = A1*B1, registered. Stage-2 sideband is copied to stage 3.
- Stage 4: P = post-add(X, Z, cin) using the stage-3 opmode. The Z=P and X=P paths use the current P register.

Latency and throughput:
- Latency is 4 edges: out_valid rises exactly 4 ce-cycles after in_valid is sampled, for exactly one cycle per sample.
- Back-to-back valid samples accumulate correctly, one result per cycle.
- ce=0 adds stall cycles without losing or duplicating samples.

## Structure
- Package dsp_slice_pkg holds:
  - X-select constants: X_ZERO, X_M, X_P, X_DAB
  - Z-select constants: Z_ZERO, Z_PCIN, Z_P, Z_C
  - opmode bit-index constants
- One sub-module, dsp_postadd: combinational X/Z mux, carry-in, add/subtract, saturation, carry-out. It is parametrised by P_W and SAT_EN.
- Pipeline registers live in the top level.

## Test plan
- Reset: drive traffic, pulse rst_n low mid-stream → all outputs 0 immediately; no out_valid for samples already in flight.
- Pre-add subtract, post subtract: opmode=8'b11011101, A=20, B=10, D=25, C=350, one valid sample → BCOUT=0xF, M=0x12C, P=0x32 with out_valid on the 4th edge, CARRYOUT=0.
- Pre-add add: opmode=8'b00010001, same operands → BCOUT=0x23, M=0x2BC, P=0x2BC.
- Accumulate with gaps: opmode=8'b00001001, A=5, B=6.
  - Valid samples on cycles 0, 3, 4 → P=0x1E, 0x3C, 0x5A; P is unchanged on invalid cycles.
  - Next sample with acc_clr=1 → P=0x1E.
- Saturation: X=M (A=5, B=6), Z=C, C=48'hFFFF_FFFF_FFF0, add.
  - SAT_EN=1 → P=48'hFFFF_FFFF_FFFF, sat=1, CARRYOUT=1.
  - SAT_EN=0 → P=0xE, sat=0, CARRYOUT=1.
- Cascade/stall: B_SRC=1, BCIN=7, PCIN=3000, opmode=8'b00100100, with ce low for 2 cycles mid-pipeline → P=3001 (0xBB9) with out_valid 6 edges after the sample, PCOUT=P, BCOUT=7.

Source files
------------

// File: rtl/dsp_slice_pkg.sv
// Shared opmode field positions and X/Z operand selector encodings for the MAC slice.
package dsp_slice_pkg;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } z_sel_e;

    localparam int OP_X_LSB   = 0;
    localparam int OP_Z_LSB   = 2;
    localparam int OP_PREADD  = 4;
    localparam int OP_CIN     = 5;
    localparam int OP_PRESUB  = 6;
    localparam int OP_POSTSUB = 7;

endpackage

// File: rtl/dsp_mac_slice_if.sv
// Sample/result bundle of the MAC slice; master is the sample source, slave is the slice.
interface dsp_mac_slice_if #(
    parameter int A_W = 18,
    parameter int B_W = 18,
    parameter int P_W = 48
);
    logic                 in_valid;
    logic                 acc_clr;
    logic [7:0]           opmode;
    logic [A_W-1:0]       A;
    logic [B_W-1:0]       B;
    logic [B_W-1:0]       D;
    logic [B_W-1:0]       BCIN;
    logic [P_W-1:0]       C;
    logic [P_W-1:0]       PCIN;

    logic [B_W-1:0]       BCOUT;
    logic [A_W+B_W-1:0]   M;
    logic [P_W-1:0]       P;
    logic [P_W-1:0]       PCOUT;
    logic                 CARRYOUT;
    logic                 CARRYOUTF;
    logic                 sat;
    logic                 out_valid;

    modport master (
        output in_valid, acc_clr, opmode, A, B, D, BCIN, C, PCIN,
        input  BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF, sat, out_valid
    );

    modport slave (
        input  in_valid, acc_clr, opmode, A, B, D, BCIN, C, PCIN,
        output BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF, sat, out_valid
    );
endinterface

// File: rtl/dsp_postadd.sv
// Combinational post-adder: X/Z operand select, carry-in, add or subtract, optional clamp.
module dsp_postadd
    import dsp_slice_pkg::*;
#(
    parameter int P_W    = 48,
    parameter int SAT_EN = 0
) (
    input  logic [7:0]     opmode_i,
    input  logic           clr_i,
    input  logic [P_W-1:0] m_i,
    input  logic [P_W-1:0] dab_i,
    input  logic [P_W-1:0] p_i,
    input  logic [P_W-1:0] pcin_i,
    input  logic [P_W-1:0] c_i,
    output logic [P_W-1:0] p_o,
    output logic           carry_o,
    output logic           sat_o
);

    logic [P_W-1:0] x_op;
    logic [P_W-1:0] z_op;
    logic [P_W:0]   cin_ext;
    logic [P_W:0]   raw;
    logic           sub;

    // Overflow on add pins to all-ones, borrow on subtract pins to zero.
    function automatic logic [P_W-1:0] clamp(input logic [P_W-1:0] v,
                                             input logic           ovf,
                                             input logic           is_sub);
        if (SAT_EN == 0 || !ovf) return v;
        return is_sub ? '0 : '1;
    endfunction

    always_comb begin
        x_op = '0;
        case (x_sel_e'(opmode_i[OP_X_LSB +: 2]))
            X_ZERO: x_op = '0;
            X_M:    x_op = m_i;
            X_P:    x_op = p_i;
            X_DAB:  x_op = dab_i;
            default: x_op = '0;
        endcase

        z_op = '0;
        case (z_sel_e'(opmode_i[OP_Z_LSB +: 2]))
            Z_ZERO: z_op = '0;
            Z_PCIN: z_op = pcin_i;
            Z_P:    z_op = p_i;
            Z_C:    z_op = c_i;
            default: z_op = '0;
        endcase
        if (clr_i) z_op = '0;

        sub     = opmode_i[OP_POSTSUB];
        cin_ext = {{P_W{1'b0}}, opmode_i[OP_CIN]};
        if (sub) raw = {1'b0, z_op} - {1'b0, x_op} - cin_ext;
        else     raw = {1'b0, z_op} + {1'b0, x_op} + cin_ext;

        carry_o = raw[P_W];
        p_o     = clamp(raw[P_W-1:0], raw[P_W], sub);
        sat_o   = (SAT_EN != 0) && raw[P_W];
    end

endmodule

// File: rtl/dsp_mac_slice.sv
// Four-stage pre-add / multiply / post-add slice with a valid bit gating accumulation.
module dsp_mac_slice
    import dsp_slice_pkg::*;
#(
    parameter int A_W    = 18,
    parameter int B_W    = 18,
    parameter int P_W    = 48,
    parameter int B_SRC  = 0,
    parameter int SAT_EN = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    dsp_mac_slice_if.slave  bus
);

    localparam int M_W   = A_W + B_W;
    localparam int DAB_W = 2 * B_W + A_W;

    logic [A_W-1:0] a_p0_q, a_p1_q, a_p2_q;
    logic [B_W-1:0] b_p0_q, b_p1_q, b_p2_q;
    logic [B_W-1:0] d_p0_q, d_p1_q, d_p2_q;
    logic [P_W-1:0] c_p0_q, c_p1_q, c_p2_q;
    logic [P_W-1:0] pcin_p0_q, pcin_p1_q, pcin_p2_q;
    logic [7:0]     op_p0_q, op_p1_q, op_p2_q;
    logic           clr_p0_q, clr_p1_q, clr_p2_q;
    logic           vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q;
    logic [M_W-1:0] m_p2_q;
    logic [P_W-1:0] p_p3_q;
    logic           co_p3_q, sat_p3_q;

    logic [B_W-1:0]   b_p0_d;
    logic [B_W-1:0]   b_p1_d;
    logic [M_W-1:0]   m_p2_d;
    logic [DAB_W-1:0] dab_full;
    logic [P_W-1:0]   m_ext, dab_ext;
    logic [P_W-1:0]   p_p3_d;
    logic             co_p3_d, sat_p3_d;

    function automatic logic [B_W-1:0] preadd(input logic           en,
                                              input logic           is_sub,
                                              input logic [B_W-1:0] d,
                                              input logic [B_W-1:0] b);
        if (!en) return b;
        return is_sub ? d - b : d + b;
    endfunction

    assign b_p0_d   = (B_SRC != 0) ? bus.BCIN : bus.B;
    assign b_p1_d   = preadd(op_p0_q[OP_PREADD], op_p0_q[OP_PRESUB], d_p0_q, b_p0_q);
    assign m_p2_d   = M_W'(a_p1_q) * M_W'(b_p1_q);
    // Size casts zero-extend or truncate the concatenation to the post-add width.
    assign dab_full = {d_p2_q, a_p2_q, b_p2_q};
    assign dab_ext  = P_W'(dab_full);
    assign m_ext    = P_W'(m_p2_q);

    dsp_postadd #(
        .P_W    (P_W),
        .SAT_EN (SAT_EN)
    ) u_postadd (
        .opmode_i (op_p2_q),
        .clr_i    (clr_p2_q),
        .m_i      (m_ext),
        .dab_i    (dab_ext),
        .p_i      (p_p3_q),
        .pcin_i   (pcin_p2_q),
        .c_i      (c_p2_q),
        .p_o      (p_p3_d),
        .carry_o  (co_p3_d),
        .sat_o    (sat_p3_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p0_q    <= '0; b_p0_q    <= '0; d_p0_q   <= '0; c_p0_q   <= '0;
            pcin_p0_q <= '0; op_p0_q   <= '0; clr_p0_q <= 1'b0; vld_p0_q <= 1'b0;
            a_p1_q    <= '0; b_p1_q    <= '0; d_p1_q   <= '0; c_p1_q   <= '0;
            pcin_p1_q <= '0; op_p1_q   <= '0; clr_p1_q <= 1'b0; vld_p1_q <= 1'b0;
            a_p2_q    <= '0; b_p2_q    <= '0; d_p2_q   <= '0; c_p2_q   <= '0;
            pcin_p2_q <= '0; op_p2_q   <= '0; clr_p2_q <= 1'b0; vld_p2_q <= 1'b0;
            m_p2_q    <= '0;
            p_p3_q    <= '0; co_p3_q   <= 1'b0; sat_p3_q <= 1'b0; vld_p3_q <= 1'b0;
        end else if (ce) begin
            // Stage 1: input capture
            a_p0_q    <= bus.A;
            b_p0_q    <= b_p0_d;
            d_p0_q    <= bus.D;
            c_p0_q    <= bus.C;
            pcin_p0_q <= bus.PCIN;
            op_p0_q   <= bus.opmode;
            clr_p0_q  <= bus.acc_clr;
            vld_p0_q  <= bus.in_valid;
            // Stage 2: pre-adder
            a_p1_q    <= a_p0_q;
            b_p1_q    <= b_p1_d;
            d_p1_q    <= d_p0_q;
            c_p1_q    <= c_p0_q;
            pcin_p1_q <= pcin_p0_q;
            op_p1_q   <= op_p0_q;
            clr_p1_q  <= clr_p0_q;
            vld_p1_q  <= vld_p0_q;
            // Stage 3: multiplier
            m_p2_q    <= m_p2_d;
            a_p2_q    <= a_p1_q;
            b_p2_q    <= b_p1_q;
            d_p2_q    <= d_p1_q;
            c_p2_q    <= c_p1_q;
            pcin_p2_q <= pcin_p1_q;
            op_p2_q   <= op_p1_q;
            clr_p2_q  <= clr_p1_q;
            vld_p2_q  <= vld_p1_q;
            // Stage 4: post-add; result state only moves on valid samples
            vld_p3_q  <= vld_p2_q;
            if (vld_p2_q) begin
                p_p3_q   <= p_p3_d;
                co_p3_q  <= co_p3_d;
                sat_p3_q <= sat_p3_d;
            end
        end
    end

    assign bus.BCOUT     = b_p1_q;
    assign bus.M         = m_p2_q;
    assign bus.P         = p_p3_q;
    assign bus.PCOUT     = p_p3_q;
    assign bus.CARRYOUT  = co_p3_q;
    assign bus.CARRYOUTF = co_p3_q;
    assign bus.sat       = sat_p3_q;
    assign bus.out_valid = vld_p3_q;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// Scoreboarded bench: two slices (B port / no clamp, BCIN / clamping) fed the same samples.
module tb_dsp_mac_slice;

    typedef struct packed {
        logic [7:0]  op;
        logic        clr;
        logic [17:0] a, b, d, bcin;
        logic [47:0] c, pcin;
    } smp_t;

    typedef struct packed {
        logic [47:0] p;
        logic        co;
        logic        sat;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ce = 1'b1;
    logic ce_was = 1'b0;

    int total = 0;
    int bad = 0;

    res_t        q[2][$];
    logic [47:0] mp[2];
    logic [47:0] last_p[2];

    dsp_mac_slice_if if0 ();
    dsp_mac_slice_if if1 ();

    dsp_mac_slice #(.B_SRC(0), .SAT_EN(0)) dut0 (.clk(clk), .rst_n(rst_n), .ce(ce), .bus(if0));
    dsp_mac_slice #(.B_SRC(1), .SAT_EN(1)) dut1 (.clk(clk), .rst_n(rst_n), .ce(ce), .bus(if1));

    always #5 clk = ~clk;
    always @(posedge clk) ce_was <= ce;

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic on the whole sample, one valid sample at a time.
    function automatic res_t model(input smp_t s, input bit bsrc, input bit saten, input logic [47:0] p);
        logic [17:0] b0, b1;
        logic [35:0] m;
        logic [53:0] dab;
        logic [47:0] x, z;
        logic [48:0] need, full;
        res_t r;
        b0 = bsrc ? s.bcin : s.b;
        if (!s.op[4])     b1 = b0;
        else if (s.op[6]) b1 = s.d - b0;
        else              b1 = s.d + b0;
        m   = 36'(s.a) * 36'(b1);
        dab = {s.d, s.a, b1};
        case (s.op[1:0])
            2'd0: x = '0;
            2'd1: x = 48'(m);
            2'd2: x = p;
            default: x = dab[47:0];
        endcase
        case (s.op[3:2])
            2'd0: z = '0;
            2'd1: z = s.pcin;
            2'd2: z = p;
            default: z = s.c;
        endcase
        if (s.clr) z = '0;
        if (s.op[7]) begin
            need = {1'b0, x} + 49'(s.op[5]);
            r.co = ({1'b0, z} < need);
            r.p  = z - x - 48'(s.op[5]);
            if (saten && r.co) r.p = '0;
        end else begin
            full = {1'b0, z} + {1'b0, x} + 49'(s.op[5]);
            r.co = full[48];
            r.p  = full[47:0];
            if (saten && r.co) r.p = '1;
        end
        r.sat = saten && r.co;
        return r;
    endfunction

    task automatic drv(input smp_t s, input bit v, input bit c);
        res_t r;
        @(negedge clk);
        ce = c;
        if0.in_valid = v; if0.acc_clr = s.clr; if0.opmode = s.op; if0.A = s.a;
        if0.B = s.b; if0.D = s.d; if0.BCIN = s.bcin; if0.C = s.c; if0.PCIN = s.pcin;
        if1.in_valid = v; if1.acc_clr = s.clr; if1.opmode = s.op; if1.A = s.a;
        if1.B = s.b; if1.D = s.d; if1.BCIN = s.bcin; if1.C = s.c; if1.PCIN = s.pcin;
        if (v && c) begin
            for (int k = 0; k < 2; k++) begin
                r = model(s, k == 1, k == 1, mp[k]);
                mp[k] = r.p;
                q[k].push_back(r);
            end
        end
    endtask

    task automatic rst_chk(input int k, input logic [17:0] bc, input logic [35:0] m, input logic [47:0] p,
                           input logic [47:0] pc, input logic [3:0] flags);
        chk("rst_BCOUT", k, 64'(bc), 64'(0));
        chk("rst_M", k, 64'(m), 64'(0));
        chk("rst_P", k, 64'(p), 64'(0));
        chk("rst_PCOUT", k, 64'(pc), 64'(0));
        chk("rst_flags", k, 64'(flags), 64'(0));
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        if0.in_valid = 1'b0;
        if1.in_valid = 1'b0;
        rst_chk(0, if0.BCOUT, if0.M, if0.P, if0.PCOUT, {if0.CARRYOUT, if0.CARRYOUTF, if0.sat, if0.out_valid});
        rst_chk(1, if1.BCOUT, if1.M, if1.P, if1.PCOUT, {if1.CARRYOUT, if1.CARRYOUTF, if1.sat, if1.out_valid});
        for (int k = 0; k < 2; k++) begin
            q[k].delete();
            mp[k] = '0;
            last_p[k] = '0;
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // One valid sample followed by idle cycles; checks stage 2, stage 3 and stage 4 at their edges.
    task automatic run_one(input string nm, input smp_t s, input logic [17:0] bc_exp, input logic [35:0] m_exp,
                           input logic [47:0] p0_exp, input logic [47:0] p1_exp, input logic co_exp,
                           input logic sat1_exp);
        drv(s, 1, 1);
        drv(s, 0, 1);
        drv(s, 0, 1);
        chk({nm, "_BCOUT"}, 0, 64'(if0.BCOUT), 64'(bc_exp));
        drv(s, 0, 1);
        chk({nm, "_M"}, 0, 64'(if0.M), 64'(m_exp));
        chk({nm, "_ov_early"}, 0, 64'(if0.out_valid), 64'(0));
        drv(s, 0, 1);
        chk({nm, "_ov"}, 0, 64'(if0.out_valid), 64'(1));
        chk({nm, "_P"}, 0, 64'(if0.P), 64'(p0_exp));
        chk({nm, "_P"}, 1, 64'(if1.P), 64'(p1_exp));
        chk({nm, "_CO"}, 0, 64'(if0.CARRYOUT), 64'(co_exp));
        chk({nm, "_CO"}, 1, 64'(if1.CARRYOUT), 64'(co_exp));
        chk({nm, "_sat"}, 0, 64'(if0.sat), 64'(0));
        chk({nm, "_sat"}, 1, 64'(if1.sat), 64'(sat1_exp));
    endtask

    function automatic smp_t rnd_smp();
        smp_t s;
        s.op   = 8'($urandom);
        s.clr  = ($urandom_range(0, 15) == 0);
        s.a    = 18'($urandom);
        s.b    = 18'($urandom);
        s.d    = 18'($urandom);
        s.bcin = 18'($urandom);
        s.c    = 48'({$urandom(), $urandom()});
        s.pcin = 48'({$urandom(), $urandom()});
        return s;
    endfunction

    // Monitor: every ce edge either pops one expected result or confirms P held still.
    res_t        mon_e;
    logic        mon_ov, mon_co, mon_cof, mon_sat;
    logic [47:0] mon_p, mon_pc;
    always @(negedge clk) begin
        if (rst_n && ce_was) begin
            for (int k = 0; k < 2; k++) begin
                mon_ov  = (k == 0) ? if0.out_valid : if1.out_valid;
                mon_p   = (k == 0) ? if0.P         : if1.P;
                mon_pc  = (k == 0) ? if0.PCOUT     : if1.PCOUT;
                mon_co  = (k == 0) ? if0.CARRYOUT  : if1.CARRYOUT;
                mon_cof = (k == 0) ? if0.CARRYOUTF : if1.CARRYOUTF;
                mon_sat = (k == 0) ? if0.sat       : if1.sat;
                if (mon_ov) begin
                    if (q[k].size() == 0) begin
                        chk("ov_without_sample", k, 64'(mon_ov), 64'(0));
                    end else begin
                        mon_e = q[k].pop_front();
                        chk("P", k, 64'(mon_p), 64'(mon_e.p));
                        chk("PCOUT", k, 64'(mon_pc), 64'(mon_e.p));
                        chk("CARRYOUT", k, 64'(mon_co), 64'(mon_e.co));
                        chk("CARRYOUTF", k, 64'(mon_cof), 64'(mon_e.co));
                        chk("sat", k, 64'(mon_sat), 64'(mon_e.sat));
                        last_p[k] = mon_e.p;
                    end
                end else begin
                    chk("P_hold", k, 64'(mon_p), 64'(last_p[k]));
                end
            end
        end
    end

    initial begin
        smp_t s;
        for (int k = 0; k < 2; k++) begin
            mp[k] = '0;
            last_p[k] = '0;
        end
        s = '0;
        if0.in_valid = 0; if0.acc_clr = 0; if0.opmode = 0; if0.A = 0; if0.B = 0;
        if0.D = 0; if0.BCIN = 0; if0.C = 0; if0.PCIN = 0;
        if1.in_valid = 0; if1.acc_clr = 0; if1.opmode = 0; if1.A = 0; if1.B = 0;
        if1.D = 0; if1.BCIN = 0; if1.C = 0; if1.PCIN = 0;
        reset_pulse();

        s = '0; s.op = 8'b11011101; s.a = 18'd20; s.b = 18'd10; s.bcin = 18'd10; s.d = 18'd25; s.c = 48'd350;
        run_one("presub_postsub", s, 18'hF, 36'h12C, 48'h32, 48'h32, 1'b0, 1'b0);

        s.op = 8'b00010001;
        run_one("preadd", s, 18'h23, 36'h2BC, 48'h2BC, 48'h2BC, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) drv(rnd_smp(), 1, 1);
        reset_pulse();
        repeat (6) drv('0, 0, 1);

        s = '0; s.op = 8'b00001001; s.a = 18'd5; s.b = 18'd6; s.bcin = 18'd6;
        drv(s, 1, 1);
        drv(s, 0, 1);
        drv(s, 0, 1);
        drv(s, 1, 1);
        drv(s, 1, 1);
        s.clr = 1'b1;
        drv(s, 1, 1);
        s.clr = 1'b0;
        repeat (5) drv(s, 0, 1);
        chk("acc_clr_P", 0, 64'(if0.P), 64'h1E);
        chk("acc_clr_P", 1, 64'(if1.P), 64'h1E);

        s = '0; s.op = 8'b00001101; s.a = 18'd5; s.b = 18'd6; s.bcin = 18'd6; s.c = 48'hFFFF_FFFF_FFF0;
        run_one("sat", s, 18'd6, 36'h1E, 48'hE, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b1);

        s = '0; s.op = 8'b00100100; s.b = 18'd9; s.bcin = 18'd7; s.pcin = 48'd3000;
        drv(s, 1, 1);
        drv(s, 0, 1);
        drv(s, 0, 0);
        chk("casc_BCOUT", 1, 64'(if1.BCOUT), 64'd7);
        drv(s, 0, 0);
        drv(s, 0, 1);
        drv(s, 0, 1);
        chk("casc_ov_early", 1, 64'(if1.out_valid), 64'(0));
        drv(s, 0, 1);
        chk("casc_ov", 1, 64'(if1.out_valid), 64'(1));
        chk("casc_P", 1, 64'(if1.P), 64'd3001);
        chk("casc_PCOUT", 1, 64'(if1.PCOUT), 64'd3001);
        chk("casc_P", 0, 64'(if0.P), 64'd3001);

        for (int i = 0; i < 400; i++) begin
            drv(rnd_smp(), $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
        end

        for (int i = 0; i < 30 && (q[0].size() != 0 || q[1].size() != 0); i++) drv('0, 0, 1);
        drv('0, 0, 1);
        chk("drain_pending", 0, 64'(q[0].size()), 64'(0));
        chk("drain_pending", 1, 64'(q[1].size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
